// File: rtl/env_gen_if.sv
// Envelope generator control/status bundle; the h_interval field exists only when ENV_GEN_HOLD_EN is defined.
// Master drives the note controls, slave (env_gen) drives the envelope status.
interface env_gen_if #(
    parameter int LVL_W = 7,
    parameter int INT_W = 16
);
    logic             gate;
    logic             retrig;
    logic [INT_W-1:0] a_interval;
    logic [INT_W-1:0] d_interval;
    logic [INT_W-1:0] r_interval;
`ifdef ENV_GEN_HOLD_EN
    logic [INT_W-1:0] h_interval;
`endif
    logic [LVL_W-1:0] sus_lvl;
    logic [LVL_W-1:0] level;
    logic [2:0]       stage;
    logic             running;
    logic             done;

`ifdef ENV_GEN_HOLD_EN
    modport master (output gate, retrig, a_interval, d_interval, r_interval, h_interval, sus_lvl,
                    input  level, stage, running, done);
    modport slave  (input  gate, retrig, a_interval, d_interval, r_interval, h_interval, sus_lvl,
                    output level, stage, running, done);
`else
    modport master (output gate, retrig, a_interval, d_interval, r_interval, sus_lvl,
                    input  level, stage, running, done);
    modport slave  (input  gate, retrig, a_interval, d_interval, r_interval, sus_lvl,
                    output level, stage, running, done);
`endif
endinterface

// File: rtl/env_gen.sv
// ADSR envelope generator with optional HOLD stage (ENV_GEN_HOLD_EN); gate edges act 3 clocks after sampling.
// Registered outputs; no backpressure, level steps once per stage interval+1 clocks.
module env_gen #(
    parameter int LVL_W = 7,
    parameter int INT_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    env_gen_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
`ifdef ENV_GEN_HOLD_EN
        S_HOLD    = 3'd2,
`endif
        S_DECAY   = 3'd3,
        S_SUSTAIN = 3'd4,
        S_RELEASE = 3'd5
    } stage_e;

    localparam logic [LVL_W-1:0] LVL_MAX  = '1;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_PRE  = LVL_MAX - LVL_ONE;
`ifdef ENV_GEN_HOLD_EN
    localparam stage_e PEAK_ST = S_HOLD;
`else
    localparam stage_e PEAK_ST = S_DECAY;
`endif

    stage_e           stage_q, stage_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [INT_W-1:0] tmr_q, tmr_d;
    logic [2:0]       sync_q, sync_d;
    logic             done_q, done_d;

    logic             rise, fall, fire;
    logic [INT_W-1:0] ivl;

    always_comb begin
        sync_d  = {sync_q[1:0], bus.gate};
        rise    = sync_q[1] & ~sync_q[2];
        fall    = ~sync_q[1] & sync_q[2];

        // IDLE and SUSTAIN use interval 0 so the timer simply stays parked at 0
        ivl = '0;
        case (stage_q)
            S_ATTACK:  ivl = bus.a_interval;
`ifdef ENV_GEN_HOLD_EN
            S_HOLD:    ivl = bus.h_interval;
`endif
            S_DECAY:   ivl = bus.d_interval;
            S_RELEASE: ivl = bus.r_interval;
            default:   ivl = '0;
        endcase
        fire = (tmr_q == ivl);

        stage_d = stage_q;
        level_d = level_q;
        done_d  = 1'b0;

        if (rise) begin
            stage_d = S_ATTACK;
            if (bus.retrig) level_d = '0;
        end else if (fall && stage_q != S_IDLE && stage_q != S_RELEASE) begin
            stage_d = S_RELEASE;
        end else begin
            case (stage_q)
                S_ATTACK: begin
                    if (level_q == LVL_MAX) begin
                        stage_d = PEAK_ST;
                    end else if (fire) begin
                        level_d = level_q + LVL_ONE;
                        if (level_q == LVL_PRE) stage_d = PEAK_ST;
                    end
                end
`ifdef ENV_GEN_HOLD_EN
                S_HOLD: begin
                    if (fire) stage_d = S_DECAY;
                end
`endif
                S_DECAY: begin
                    if (level_q <= bus.sus_lvl) begin
                        stage_d = S_SUSTAIN;
                    end else if (fire) begin
                        level_d = level_q - LVL_ONE;
                        if (level_d == '0) begin
                            stage_d = S_IDLE;
                            done_d  = 1'b1;
                        end else if (level_d == bus.sus_lvl) begin
                            stage_d = S_SUSTAIN;
                        end
                    end
                end
                S_SUSTAIN: level_d = bus.sus_lvl;
                S_RELEASE: begin
                    if (level_q == '0) begin
                        stage_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (fire) begin
                        level_d = level_q - LVL_ONE;
                        if (level_d == '0) begin
                            stage_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_IDLE:  stage_d = S_IDLE;
                default: stage_d = S_IDLE;
            endcase
        end

        // Any stage entry (including a re-triggered ATTACK) restarts the step period
        if (stage_d != stage_q || rise || fire) tmr_d = '0;
        else                                    tmr_d = tmr_q + INT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= S_IDLE;
            level_q <= '0;
            tmr_q   <= '0;
            sync_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            level_q <= level_d;
            tmr_q   <= tmr_d;
            sync_q  <= sync_d;
            done_q  <= done_d;
        end
    end

    assign bus.level   = level_q;
    assign bus.stage   = stage_q;
    assign bus.running = (stage_q != S_IDLE);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_env_gen.sv
// Randomised envelope episodes checked against closed-form timing predictions, plus directed corner cases.
module tb_env_gen;
    localparam int LVL_W = 7;
    localparam int INT_W = 16;
    localparam int MAXL  = 127;
    localparam int ST_IDLE = 0, ST_ATT = 1, ST_HOLD = 2, ST_DEC = 3, ST_SUS = 4, ST_REL = 5;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;

    env_gen_if #(.LVL_W(LVL_W), .INT_W(INT_W)) bus ();
    env_gen #(.LVL_W(LVL_W), .INT_W(INT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_lvl(input string tag, input int lv, input int budget);
        int n = 0;
        while (bus.level !== LVL_W'(lv) && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) chk(tag, bus.level, lv);
    endtask

    task automatic wait_stage(input string tag, input int st, input int budget);
        int n = 0;
        while (bus.stage !== 3'(st) && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) chk(tag, bus.stage, st);
    endtask

    task automatic do_reset();
        bus.gate = 1'b0;
        rst = 1'b1;
        step(2);
        chk("rst_level", bus.level, 0);
        chk("rst_stage", bus.stage, ST_IDLE);
        chk("rst_running", bus.running, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        done_cnt = 0;
    endtask

    // One full gate-on / gate-off episode; every expected value is a closed-form step count.
    task automatic episode(input int a, input int d, input int r, input int h, input int s, input int s2);
        int t;
        int rel;
        do_reset();
        bus.a_interval = INT_W'(a);
        bus.d_interval = INT_W'(d);
        bus.r_interval = INT_W'(r);
`ifdef ENV_GEN_HOLD_EN
        bus.h_interval = INT_W'(h);
`endif
        bus.sus_lvl = LVL_W'(s);
        bus.retrig  = 1'b1;
        bus.gate    = 1'b1;
        step(2);
        chk("gate_latency_idle", bus.stage, ST_IDLE);
        step(1);
        chk("attack_entry", bus.stage, ST_ATT);
        chk("attack_lvl0", bus.level, 0);
        chk("attack_running", bus.running, 1);
        t = $urandom_range(1, MAXL * (a + 1) - 2);
        step(t);
        chk("attack_ramp", bus.level, t / (a + 1));
        step(MAXL * (a + 1) - 1 - t);
        chk("attack_pre_peak", bus.level, MAXL - 1);
        step(1);
        chk("attack_peak", bus.level, MAXL);
`ifdef ENV_GEN_HOLD_EN
        chk("hold_entry", bus.stage, ST_HOLD);
        step(h);
        chk("hold_last", bus.stage, ST_HOLD);
        chk("hold_lvl", bus.level, MAXL);
        step(1);
`endif
        chk("decay_entry", bus.stage, ST_DEC);
        if (s > 0) begin
            step((MAXL - s) * (d + 1) - 1);
            chk("decay_pre_sus", bus.level, s + 1);
            step(1);
            chk("sustain_entry", bus.stage, ST_SUS);
            chk("sustain_lvl", bus.level, s);
            bus.sus_lvl = LVL_W'(s2);
            step(1);
            chk("sustain_track", bus.level, s2);
            bus.gate = 1'b0;
            step(3);
            chk("release_entry", bus.stage, ST_REL);
            chk("release_from_lvl", bus.level, s2);
            rel = (s2 == 0) ? 1 : s2 * (r + 1);
            step(rel - 1);
            chk("release_pre_end", bus.done, 0);
            step(1);
            chk("release_end_lvl", bus.level, 0);
            chk("release_end_stage", bus.stage, ST_IDLE);
            chk("release_done", bus.done, 1);
            step(1);
            chk("done_single", bus.done, 0);
        end else begin
            step(MAXL * (d + 1) - 1);
            chk("decay0_pre_end", bus.level, 1);
            step(1);
            chk("decay0_lvl", bus.level, 0);
            chk("decay0_stage", bus.stage, ST_IDLE);
            chk("decay0_done", bus.done, 1);
            step(1);
            chk("decay0_done_single", bus.done, 0);
            bus.gate = 1'b0;
            step(5);
            chk("idle_fall_ignored", bus.stage, ST_IDLE);
        end
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        int a, d, r, h, s, s2;
        rst = 1'b1;
        bus.gate = 1'b0;
        bus.retrig = 1'b1;
        bus.a_interval = '0;
        bus.d_interval = '0;
        bus.r_interval = '0;
`ifdef ENV_GEN_HOLD_EN
        bus.h_interval = '0;
`endif
        bus.sus_lvl = '0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            a  = $urandom_range(0, 3);
            d  = $urandom_range(0, 3);
            r  = $urandom_range(0, 3);
            h  = $urandom_range(0, 5);
            s  = (i == 1) ? 0 : $urandom_range(1, 126);
            s2 = (i == 2) ? 0 : $urandom_range(1, 126);
            if (i == 0) begin
                a = 3;
                d = 1;
                s = 64;
            end
            episode(a, d, r, h, s, s2);
        end

        // Gate fall at level 40 mid-attack, immediate release
        do_reset();
        bus.a_interval = 16'd3;
        bus.d_interval = 16'd0;
        bus.r_interval = 16'd0;
        bus.sus_lvl = 7'd10;
        bus.retrig = 1'b1;
        bus.gate = 1'b1;
        wait_lvl("wait_lvl40_timeout", 40, 1000);
        chk("fall40_in_attack", bus.stage, ST_ATT);
        bus.gate = 1'b0;
        step(2);
        chk("fall40_pending_lvl", bus.level, 40);
        step(1);
        chk("fall40_release", bus.stage, ST_REL);
        chk("fall40_release_lvl", bus.level, 40);
        step(39);
        chk("fall40_lvl1", bus.level, 1);
        step(1);
        chk("fall40_lvl0", bus.level, 0);
        chk("fall40_idle", bus.stage, ST_IDLE);
        chk("fall40_done", bus.done, 1);
        step(1);
        chk("fall40_done_low", bus.done, 0);
        chk("fall40_done_count", done_cnt, 1);

        // Re-rise during release: legato then retrigger
        do_reset();
        bus.a_interval = 16'd0;
        bus.d_interval = 16'd0;
        bus.r_interval = 16'd3;
`ifdef ENV_GEN_HOLD_EN
        bus.h_interval = 16'd0;
`endif
        bus.sus_lvl = 7'd100;
        bus.retrig = 1'b0;
        bus.gate = 1'b1;
        wait_stage("wait_sus_timeout", ST_SUS, 1000);
        bus.gate = 1'b0;
        wait_lvl("wait_rel50_timeout", 50, 1000);
        bus.gate = 1'b1;
        step(3);
        chk("legato_stage", bus.stage, ST_ATT);
        chk("legato_lvl", bus.level, 50);
        step(1);
        chk("legato_next", bus.level, 51);
        bus.gate = 1'b0;
        step(3);
        chk("legato_fall_lvl", bus.level, 53);
        wait_lvl("wait_rel50b_timeout", 50, 1000);
        bus.retrig = 1'b1;
        bus.gate = 1'b1;
        step(3);
        chk("retrig_stage", bus.stage, ST_ATT);
        chk("retrig_lvl", bus.level, 0);

        // Reset mid-decay, gate held high through reset release
        do_reset();
        bus.a_interval = 16'd0;
        bus.d_interval = 16'd3;
        bus.sus_lvl = 7'd20;
        bus.gate = 1'b1;
        wait_stage("wait_dec_timeout", ST_DEC, 1000);
        step(10);
        rst = 1'b1;
        done_cnt = 0;
        step(1);
        chk("midrst_lvl", bus.level, 0);
        chk("midrst_stage", bus.stage, ST_IDLE);
        chk("midrst_running", bus.running, 0);
        chk("midrst_done", bus.done, 0);
        rst = 1'b0;
        step(2);
        chk("postrst_wait", bus.stage, ST_IDLE);
        step(1);
        chk("postrst_rise", bus.stage, ST_ATT);
        chk("midrst_no_done", done_cnt, 0);

`ifdef ENV_GEN_HOLD_EN
        begin
            int n;
            do_reset();
            bus.a_interval = 16'd0;
            bus.h_interval = 16'd9;
            bus.d_interval = 16'd0;
            bus.sus_lvl = 7'd64;
            bus.gate = 1'b1;
            wait_stage("wait_hold_timeout", ST_HOLD, 1000);
            n = 0;
            while (bus.stage === 3'(ST_HOLD) && bus.level === 7'd127 && n < 100) begin
                step(1);
                n++;
            end
            chk("hold_len", n, 10);
            chk("hold_exit", bus.stage, ST_DEC);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
